// File: rtl/flash_sample_streamer.sv
// rtl/flash_sample_streamer.sv - Avalon-MM flash read master that streams 16-bit samples
module flash_sample_streamer #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              reverse,
    input  logic              loop_en,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [15:0]       sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_EMIT0,
        S_EMIT1,
        S_NEXT
    } state_t;

    localparam logic [ADDR_W-1:0] LP_ONE = 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_word;
    logic              r_rev;
    logic              r_loop;
    logic              r_done;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_range_first;

    // The "end" of the range depends on direction; looping restarts from the opposite end.
    assign w_at_end      = r_rev ? (r_addr == START_ADDR) : (r_addr == END_ADDR);
    assign w_range_first = r_rev ? END_ADDR : START_ADDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= START_ADDR;
            r_word  <= 32'h0;
            r_rev   <= 1'b0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rev  <= reverse;
                        r_loop <= loop_en;
                        r_addr <= reverse ? END_ADDR : START_ADDR;
                    end
                end
                S_WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        r_word <= flash_mem_readdata;
                    end
                end
                S_NEXT: begin
                    if (w_at_end) begin
                        if (r_loop) begin
                            r_addr <= w_range_first;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else if (r_rev) begin
                        r_addr <= r_addr - LP_ONE;
                    end else begin
                        r_addr <= r_addr + LP_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_REQ;
            S_REQ:       if (!flash_mem_waitrequest) w_next_state = S_WAIT_DATA;
            S_WAIT_DATA: if (flash_mem_readdatavalid) w_next_state = S_EMIT0;
            S_EMIT0:     if (sample_ready) w_next_state = S_EMIT1;
            S_EMIT1:     if (sample_ready) w_next_state = S_NEXT;
            S_NEXT:      w_next_state = (w_at_end && !r_loop) ? S_IDLE : S_REQ;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Reverse playback emits the upper half first so samples come out time-reversed.
    always_comb begin
        flash_mem_read = 1'b0;
        sample_valid   = 1'b0;
        sample_data    = 16'h0;
        case (r_state)
            S_REQ: flash_mem_read = 1'b1;
            S_EMIT0: begin
                sample_valid = 1'b1;
                sample_data  = r_rev ? r_word[31:16] : r_word[15:0];
            end
            S_EMIT1: begin
                sample_valid = 1'b1;
                sample_data  = r_rev ? r_word[15:0] : r_word[31:16];
            end
            default: begin
            end
        endcase
    end

    assign flash_mem_address = r_addr;
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// tb/tb_flash_sample_streamer.sv - self-checking bench for flash_sample_streamer
module tb_flash_sample_streamer;

    localparam int AW = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start   [2];
    logic        reverse [2];
    logic        loop_en [2];
    logic        wr      [2];
    logic        rdy     [2];
    logic        rdv     [2];
    logic [31:0] rdata   [2];

    wire          rd     [2];
    wire [AW-1:0] addr   [2];
    wire [15:0]   sdata  [2];
    wire          svalid [2];
    wire          busy   [2];
    wire          done   [2];

    int          rs [2] = '{0, 5};
    int          re [2] = '{2, 5};
    logic [31:0] mem [2][8];
    int          lat [2];

    int n_tests = 0;
    int n_fail  = 0;

    flash_sample_streamer #(.ADDR_W(AW), .START_ADDR(23'd0), .END_ADDR(23'd2)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .reverse(reverse[0]), .loop_en(loop_en[0]),
        .flash_mem_read(rd[0]), .flash_mem_address(addr[0]), .flash_mem_waitrequest(wr[0]),
        .flash_mem_readdata(rdata[0]), .flash_mem_readdatavalid(rdv[0]),
        .sample_data(sdata[0]), .sample_valid(svalid[0]), .sample_ready(rdy[0]),
        .busy(busy[0]), .done(done[0])
    );

    flash_sample_streamer #(.ADDR_W(AW), .START_ADDR(23'd5), .END_ADDR(23'd5)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .reverse(reverse[1]), .loop_en(loop_en[1]),
        .flash_mem_read(rd[1]), .flash_mem_address(addr[1]), .flash_mem_waitrequest(wr[1]),
        .flash_mem_readdata(rdata[1]), .flash_mem_readdatavalid(rdv[1]),
        .sample_data(sdata[1]), .sample_valid(svalid[1]), .sample_ready(rdy[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Flash slave: answers each accepted read after lat[k] extra cycles, even across a DUT reset.
    logic          pend     [2] = '{1'b0, 1'b0};
    int            pend_cnt [2] = '{0, 0};
    logic [AW-1:0] paddr    [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rdv[k] <= 1'b0;
            if (pend[k]) begin
                if (pend_cnt[k] == 0) begin
                    rdv[k]   <= 1'b1;
                    rdata[k] <= mem[k][paddr[k][2:0]];
                    pend[k]  <= 1'b0;
                end else begin
                    pend_cnt[k] <= pend_cnt[k] - 1;
                end
            end else if (rd[k] && !wr[k]) begin
                if (lat[k] == 0) begin
                    rdv[k]   <= 1'b1;
                    rdata[k] <= mem[k][addr[k][2:0]];
                end else begin
                    pend[k]     <= 1'b1;
                    paddr[k]    <= addr[k];
                    pend_cnt[k] <= lat[k] - 1;
                end
            end
        end
    end

    function automatic logic [AW-1:0] model_addr(input int k, input bit rev, input bit lp, input int i);
        int n;
        int w;
        n = re[k] - rs[k] + 1;
        w = lp ? (i % n) : ((i < n) ? i : n - 1);
        return AW'(rev ? (re[k] - w) : (rs[k] + w));
    endfunction

    function automatic logic [15:0] model_sample(input int k, input bit rev, input bit lp, input int j);
        logic [31:0] word;
        bit          take_hi;
        word    = mem[k][model_addr(k, rev, lp, j / 2) & 7];
        take_hi = rev ? ((j % 2) == 0) : ((j % 2) == 1);
        return take_hi ? word[31:16] : word[15:0];
    endfunction

    task automatic check_reset_values(input int k, input string tag);
        n_tests++;
        if (rd[k] !== 1'b0 || addr[k] !== AW'(rs[k]) || sdata[k] !== 16'h0 ||
            svalid[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s k=%0d got rd=%b addr=%h data=%h valid=%b busy=%b done=%b expected 0/%h/0/0/0/0",
                     tag, k, rd[k], addr[k], sdata[k], svalid[k], busy[k], done[k], AW'(rs[k]));
        end
    endtask

    // wr_mode: 0 never stall, 1 random, 2 stall first request 5 cycles
    // rd_mode: 0 always ready, 1 random, 2 hold first sample 4 cycles
    task automatic run_stream(input int k, input bit rev, input bit lp, input int wr_mode,
                              input int rd_mode, input int n_samp);
        int          total;
        int          samp_i;
        int          word_i;
        int          dones;
        int          extra;
        int          wait_left;
        int          hold_left;
        int          cyc;
        bit          fin;
        bit          prev_stall;
        bit          prev_hold;
        logic [AW-1:0] prev_addr;
        logic [15:0] prev_data;
        logic [15:0] exp_s;
        logic [AW-1:0] exp_a;

        total      = lp ? n_samp : 2 * (re[k] - rs[k] + 1);
        samp_i     = 0;
        word_i     = 0;
        dones      = 0;
        extra      = 0;
        wait_left  = 5;
        hold_left  = 4;
        fin        = 1'b0;
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;

        @(negedge clk);
        start[k]   = 1'b1;
        reverse[k] = rev;
        loop_en[k] = lp;
        wr[k]      = 1'b0;
        rdy[k]     = 1'b1;
        @(negedge clk);
        start[k]   = 1'b0;
        exp_a      = model_addr(k, rev, lp, 0);
        n_tests++;
        if (rd[k] !== 1'b1 || busy[k] !== 1'b1 || addr[k] !== exp_a) begin
            n_fail++;
            $display("FAIL start_latency k=%0d got rd=%b busy=%b addr=%h expected 1/1/%h",
                     k, rd[k], busy[k], addr[k], exp_a);
        end

        for (cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (prev_stall) begin
                n_tests++;
                if (rd[k] !== 1'b1 || addr[k] !== prev_addr) begin
                    n_fail++;
                    $display("FAIL req_hold k=%0d got rd=%b addr=%h expected 1/%h", k, rd[k], addr[k], prev_addr);
                end
            end
            if (prev_hold) begin
                n_tests++;
                if (svalid[k] !== 1'b1 || sdata[k] !== prev_data) begin
                    n_fail++;
                    $display("FAIL sample_hold k=%0d got valid=%b data=%h expected 1/%h", k, svalid[k], sdata[k], prev_data);
                end
            end
            if (svalid[k] === 1'b1) begin
                n_tests++;
                if (rd[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_during_emit k=%0d got rd=%b expected 0", k, rd[k]);
                end
            end
            if (done[k] === 1'b1) begin
                dones++;
                n_tests++;
                if (busy[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_busy k=%0d got busy=%b expected 0", k, busy[k]);
                end
            end

            case (wr_mode)
                1: wr[k] = 1'($urandom % 2);
                2: begin
                    wr[k] = 1'b0;
                    if (rd[k] === 1'b1 && wait_left > 0) begin
                        wr[k] = 1'b1;
                        wait_left--;
                    end
                end
                default: wr[k] = 1'b0;
            endcase
            case (rd_mode)
                1: rdy[k] = 1'($urandom % 2);
                2: begin
                    rdy[k] = 1'b1;
                    if (svalid[k] === 1'b1 && hold_left > 0) begin
                        rdy[k] = 1'b0;
                        hold_left--;
                    end
                end
                default: rdy[k] = 1'b1;
            endcase

            if (rd[k] === 1'b1 && !wr[k]) begin
                exp_a = model_addr(k, rev, lp, word_i);
                n_tests++;
                if (addr[k] !== exp_a) begin
                    n_fail++;
                    $display("FAIL read_addr k=%0d word=%0d got %h expected %h", k, word_i, addr[k], exp_a);
                end
                word_i++;
            end
            if (svalid[k] === 1'b1 && rdy[k]) begin
                exp_s = model_sample(k, rev, lp, samp_i);
                n_tests++;
                if (sdata[k] !== exp_s) begin
                    n_fail++;
                    $display("FAIL sample k=%0d idx=%0d got %h expected %h", k, samp_i, sdata[k], exp_s);
                end
                samp_i++;
            end
            prev_stall = (rd[k] === 1'b1) && wr[k];
            prev_addr  = addr[k];
            prev_hold  = (svalid[k] === 1'b1) && !rdy[k];
            prev_data  = sdata[k];

            if (lp) begin
                fin = (samp_i >= total);
            end else if (dones > 0) begin
                extra++;
                fin = (extra >= 4);
            end
            @(negedge clk);
        end

        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL timeout k=%0d got samples=%0d expected %0d", k, samp_i, total);
        end
        n_tests++;
        if (dones != (lp ? 0 : 1)) begin
            n_fail++;
            $display("FAIL done_count k=%0d got %0d expected %0d", k, dones, lp ? 0 : 1);
        end
        if (!lp) begin
            n_tests++;
            if (busy[k] !== 1'b0 || samp_i != total || word_i != total / 2) begin
                n_fail++;
                $display("FAIL completion k=%0d got busy=%b samples=%0d words=%0d expected 0/%0d/%0d",
                         k, busy[k], samp_i, word_i, total, total / 2);
            end
        end else begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (4) @(negedge clk);
        end
        wr[k]  = 1'b0;
        rdy[k] = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values(0, "reset_state");
        check_reset_values(1, "reset_state");
    endtask

    task automatic test_forward;
        lat[0] = 0;
        run_stream(0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reverse;
        lat[0] = 0;
        run_stream(0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_waitrequest;
        lat[0] = 0;
        run_stream(0, 1'b0, 1'b0, 2, 0, 0);
    endtask

    task automatic test_backpressure;
        lat[0] = 0;
        run_stream(0, 1'b0, 1'b0, 0, 2, 0);
    endtask

    task automatic test_loop_single;
        lat[1] = 0;
        run_stream(1, 1'b0, 1'b1, 0, 0, 12);
        lat[1] = 2;
        run_stream(1, 1'b1, 1'b1, 1, 1, 8);
        run_stream(1, 1'b0, 1'b0, 1, 1, 0);
    endtask

    task automatic test_reset_mid_read;
        int cyc;
        lat[0] = 1;
        @(negedge clk);
        start[0]   = 1'b1;
        reverse[0] = 1'b0;
        loop_en[0] = 1'b0;
        wr[0]      = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        for (cyc = 0; cyc < 20 && rd[0] !== 1'b1; cyc++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values(0, "reset_mid_read");
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (svalid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL late_rdv_ignored got valid=%b busy=%b expected 0/0", svalid[0], busy[0]);
            end
        end
        lat[0] = 0;
        run_stream(0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random;
        bit rev;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 3; a++) mem[0][a] = $urandom;
            lat[0] = int'($urandom_range(0, 3));
            rev    = 1'($urandom % 2);
            run_stream(0, rev, 1'b0, 1, 1, 0);
        end
        lat[0] = int'($urandom_range(0, 2));
        run_stream(0, 1'b0, 1'b1, 1, 1, 14);
        run_stream(0, 1'b1, 1'b1, 1, 1, 14);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k]   = 1'b0;
            reverse[k] = 1'b0;
            loop_en[k] = 1'b0;
            wr[k]      = 1'b0;
            rdy[k]     = 1'b1;
            lat[k]     = 0;
            for (int a = 0; a < 8; a++) mem[k][a] = 32'h0;
        end
        mem[0][0] = 32'h11112222;
        mem[0][1] = 32'h33334444;
        mem[0][2] = 32'h55556666;
        mem[1][5] = 32'hAAAABBBB;

        test_reset;
        test_forward;
        test_reverse;
        test_waitrequest;
        test_backpressure;
        test_loop_single;
        test_reset_mid_read;
        test_random;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
